inst_fetch_if: RTL and testbench
================================

Name: inst_fetch_if

Overview:
- Responder side of the PC/chip-enable fetch interface. Takes pc/ce from the PC register and performs one instruction read per PC over a req/ack instruction bus.
- Holds the fetched word in an output slot for the IF/ID stage.
- Raises stallreq to the stall controller so the PC advances exactly once per completed fetch.
- Non-pipelined: at most one outstanding bus read.

Parameters:
- TIMEOUT_CYCLES, 255: max cycles bus_req_o may wait for bus_ack_i before the fetch is aborted with an error (1..255).

Ports:
- clk  in  1  clock, all state updates on rising edge
- rst  in  1  synchronous reset, active-high
- ce_i  in  1  fetch enable from PC register (1 = enabled)
- pc_i  in  32  fetch address from PC register
- stall_i  in  6  stall vector from controller; stall_i[1]=1 means IF/ID holds (output slot not consumed)
- flush_i  in  1  pipeline flush (exception); discards slot and any in-flight fetch
- stallreq_o  out  1  request to controller to hold PC and earlier stages
- bus_req_o  out  1  instruction-bus read request
- bus_addr_o  out  32  word address; {pc[31:2],2'b00}
- bus_ack_i  in  1  read complete; bus_rdata_i valid this cycle
- bus_rdata_i  in  32  read data
- pc_o  out  32  PC of the word held in the output slot
- inst_o  out  32  fetched instruction
- inst_valid_o  out  1  output slot full
- fetch_err_o  out  1  slot holds a timed-out fetch (inst_o=0, a NOP)

Behaviour:
- Reset (rst=1 at edge): state=IDLE; bus_req_o=0, bus_addr_o=0, pc_o=0, inst_o=0, inst_valid_o=0, fetch_err_o=0; timeout counter=0. Reset takes effect mid-transaction: req drops immediately, and an in-flight ack is ignored.
- Slot free (slot_free) = !inst_valid_o || !stall_i[1].
  - Slot consumed at an edge when inst_valid_o=1 and stall_i[1]=0.
  - inst_valid_o clears at that edge unless refilled at the same edge.
- States: IDLE, WAIT, DISCARD.
- IDLE:
  - If ce_i=1, slot_free=1 and flush_i=0: latch bus_addr_o<={pc_i[31:2],2'b00}, latch the issued pc internally, set bus_req_o<=1, counter<=0, go to WAIT.
  - Otherwise stay in IDLE.
- WAIT:
  - bus_req_o and bus_addr_o stay stable until ack. The bus may ack in the first cycle req is high.
  - On bus_ack_i=1 with flush_i=0: inst_o<=bus_rdata_i, pc_o<=issued pc, inst_valid_o<=1, fetch_err_o<=0, bus_req_o<=0, go to IDLE.
  - On counter==TIMEOUT_CYCLES-1 without ack: bus_req_o<=0, inst_o<=0, pc_o<=issued pc, inst_valid_o<=1, fetch_err_o<=1, go to IDLE.
  - Otherwise counter increments.
  - ce_i falling during WAIT does not abort the transaction.
- DISCARD: bus_req_o stays high until bus_ack_i or timeout. The returned data is dropped and the slot is not written. Then go to IDLE.
- Flush (flush_i=1 at edge): inst_valid_o<=0 and fetch_err_o<=0.
  - WAIT without ack → DISCARD.
  - WAIT with ack at the same edge → data dropped, go to IDLE.
  - IDLE: no issue this cycle.
  - Flush has priority over slot refill.
- stallreq_o (combinational) = (IDLE && ce_i) || (WAIT && !bus_ack_i && !timeout_hit) || DISCARD.
  - The PC therefore advances only at the ack/timeout edge.
  - Minimum 2 cycles per instruction (IDLE issue, WAIT ack).
- ce_i=0 in IDLE: stallreq_o=0, no request issued, slot contents unaffected except by consumption.

Test Plan:
- Reset then ce_i=1, pc_i=0x00000000, ack 1 cycle after req with rdata=0x34011100:
  - bus_req_o high exactly 1 cycle, bus_addr_o=0.
  - Next cycle: inst_o=0x34011100, pc_o=0, inst_valid_o=1.
  - stallreq_o=1 for the IDLE and req cycles, 0 in the ack cycle.
- Back-to-back fetches 0x0, 0x4, 0x8, ack latency 3, stall_i=0:
  - Each address requested once, in order.
  - stallreq_o low only in ack cycles.
  - 3 valid words appear, each 1 cycle after its ack.
- stall_i[1]=1 held 5 cycles with slot full:
  - No new bus_req_o.
  - inst_o/pc_o held constant.
  - Request issues in the cycle stall_i[1] returns to 0.
- flush_i pulse 2 cycles into a WAIT, with ack arriving 4 cycles later:
  - State goes to DISCARD; bus_req_o stays high until the ack.
  - Slot stays empty; no inst_valid_o rise.
  - Then the fetch of the new pc_i proceeds.
- No ack, TIMEOUT_CYCLES=4:
  - bus_req_o drops after 4 cycles high.
  - inst_o=0, fetch_err_o=1, inst_valid_o=1.
  - stallreq_o falls in the timeout cycle.
- rst=1 asserted while in WAIT with bus_req_o=1:
  - Next cycle all outputs are 0 and state is IDLE.
  - An ack arriving during or after reset does not set inst_valid_o.

Source files
------------

// File: rtl/inst_fetch_if_if.sv
// rtl/inst_fetch_if_if.sv - instruction-bus read handshake (req/addr out, ack/rdata back)
interface inst_fetch_if_if;
  logic        bus_req;
  logic [31:0] bus_addr;
  logic        bus_ack;
  logic [31:0] bus_rdata;

  modport master (output bus_req, output bus_addr, input bus_ack, input bus_rdata);
  modport slave  (input bus_req, input bus_addr, output bus_ack, output bus_rdata);
endinterface

// File: rtl/inst_fetch_if.sv
// rtl/inst_fetch_if.sv - single-outstanding instruction fetch with output slot, flush and timeout
module inst_fetch_if #(
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   ce_i,
  input  logic [31:0]            pc_i,
  input  logic [5:0]             stall_i,
  input  logic                   flush_i,
  output logic                   stallreq_o,
  inst_fetch_if_if.master        bus,
  output logic [31:0]            pc_o,
  output logic [31:0]            inst_o,
  output logic                   inst_valid_o,
  output logic                   fetch_err_o
);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_DISCARD} state_t;

  state_t      state_q, state_d;
  logic [7:0]  cnt_q;
  logic [31:0] issued_pc_q;
  logic        slot_free;
  logic        timeout_hit;
  logic        issue;
  logic        fill_data;
  logic        fill_err;
  logic        unused_stall;

  assign unused_stall = ^{stall_i[5:2], stall_i[0]};

  // A full slot still counts as free when IF/ID consumes it at this same edge.
  assign slot_free   = !inst_valid_o || !stall_i[1];
  assign timeout_hit = (cnt_q == 8'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d   = state_q;
    issue     = 1'b0;
    fill_data = 1'b0;
    fill_err  = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (ce_i && slot_free && !flush_i) begin
          issue   = 1'b1;
          state_d = S_WAIT;
        end
      end
      S_WAIT: begin
        if (bus.bus_ack) begin
          state_d   = S_IDLE;
          fill_data = !flush_i;
        end else if (timeout_hit) begin
          state_d  = S_IDLE;
          fill_err = !flush_i;
        end else if (flush_i) begin
          state_d = S_DISCARD;
        end
      end
      S_DISCARD: begin
        if (bus.bus_ack || timeout_hit) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // PC may only advance on the edge that completes (or aborts) a fetch.
  assign stallreq_o = ((state_q == S_IDLE) && ce_i) ||
                      ((state_q == S_WAIT) && !bus.bus_ack && !timeout_hit) ||
                      (state_q == S_DISCARD);

  always_ff @(posedge clk) begin
    if (rst) begin
      bus.bus_req  <= 1'b0;
      bus.bus_addr <= 32'h0;
      issued_pc_q  <= 32'h0;
      cnt_q        <= 8'h0;
    end else if (issue) begin
      bus.bus_req  <= 1'b1;
      bus.bus_addr <= {pc_i[31:2], 2'b00};
      issued_pc_q  <= pc_i;
      cnt_q        <= 8'h0;
    end else if (state_q != S_IDLE) begin
      if (state_d == S_IDLE) bus.bus_req <= 1'b0;
      else                   cnt_q       <= cnt_q + 8'd1;
    end
  end

  // Flush wins over refill; consumption only empties the slot when nothing refills it.
  always_ff @(posedge clk) begin
    if (rst) begin
      pc_o         <= 32'h0;
      inst_o       <= 32'h0;
      inst_valid_o <= 1'b0;
      fetch_err_o  <= 1'b0;
    end else if (flush_i) begin
      inst_valid_o <= 1'b0;
      fetch_err_o  <= 1'b0;
    end else if (fill_data) begin
      inst_o       <= bus.bus_rdata;
      pc_o         <= issued_pc_q;
      inst_valid_o <= 1'b1;
      fetch_err_o  <= 1'b0;
    end else if (fill_err) begin
      inst_o       <= 32'h0;
      pc_o         <= issued_pc_q;
      inst_valid_o <= 1'b1;
      fetch_err_o  <= 1'b1;
    end else if (inst_valid_o && !stall_i[1]) begin
      inst_valid_o <= 1'b0;
    end
  end

endmodule

// File: tb/tb_inst_fetch_if.sv
// tb/tb_inst_fetch_if.sv - directed self-checking bench for inst_fetch_if
module tb_inst_fetch_if;
  logic        clk = 1'b0;
  logic        rst;
  logic        ce_i;
  logic [31:0] pc_i;
  logic [5:0]  stall_i;
  logic        flush_i;

  logic        stallreq_m, valid_m, err_m;
  logic [31:0] pc_m, inst_m;
  logic        stallreq_t, valid_t, err_t;
  logic [31:0] pc_t, inst_t;

  int passed = 0;
  int total  = 0;

  inst_fetch_if_if bus_m ();
  inst_fetch_if_if bus_t ();

  always #5 clk = ~clk;

  inst_fetch_if dut (
    .clk(clk), .rst(rst), .ce_i(ce_i), .pc_i(pc_i), .stall_i(stall_i), .flush_i(flush_i),
    .stallreq_o(stallreq_m), .bus(bus_m), .pc_o(pc_m), .inst_o(inst_m),
    .inst_valid_o(valid_m), .fetch_err_o(err_m)
  );

  inst_fetch_if #(.TIMEOUT_CYCLES(4)) dut_to (
    .clk(clk), .rst(rst), .ce_i(ce_i), .pc_i(pc_i), .stall_i(stall_i), .flush_i(flush_i),
    .stallreq_o(stallreq_t), .bus(bus_t), .pc_o(pc_t), .inst_o(inst_t),
    .inst_valid_o(valid_t), .fetch_err_o(err_t)
  );

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset;
    rst = 1'b1; ce_i = 1'b0; pc_i = 32'h0; stall_i = 6'h0; flush_i = 1'b0;
    bus_m.bus_ack = 1'b0; bus_m.bus_rdata = 32'h0;
    bus_t.bus_ack = 1'b0; bus_t.bus_rdata = 32'h0;
    step();
    step();
    rst = 1'b0;
    #1;
  endtask

  task automatic test_reset;
    do_reset();
    total++; if (bus_m.bus_req !== 1'b0) $display("FAIL rst_req act=%0h exp=0", bus_m.bus_req); else passed++;
    total++; if (bus_m.bus_addr !== 32'h0) $display("FAIL rst_addr act=%0h exp=0", bus_m.bus_addr); else passed++;
    total++; if (pc_m !== 32'h0) $display("FAIL rst_pc act=%0h exp=0", pc_m); else passed++;
    total++; if (inst_m !== 32'h0) $display("FAIL rst_inst act=%0h exp=0", inst_m); else passed++;
    total++; if (valid_m !== 1'b0) $display("FAIL rst_valid act=%0h exp=0", valid_m); else passed++;
    total++; if (err_m !== 1'b0) $display("FAIL rst_err act=%0h exp=0", err_m); else passed++;
    total++; if (stallreq_m !== 1'b0) $display("FAIL rst_stallreq act=%0h exp=0", stallreq_m); else passed++;
  endtask

  task automatic test_single;
    do_reset();
    ce_i = 1'b1; pc_i = 32'h0;
    #1;
    total++; if (stallreq_m !== 1'b1) $display("FAIL single_idle_stallreq act=%0h exp=1", stallreq_m); else passed++;
    total++; if (bus_m.bus_req !== 1'b0) $display("FAIL single_idle_req act=%0h exp=0", bus_m.bus_req); else passed++;
    step();
    bus_m.bus_ack = 1'b1; bus_m.bus_rdata = 32'h34011100;
    #1;
    total++; if (bus_m.bus_req !== 1'b1) $display("FAIL single_req act=%0h exp=1", bus_m.bus_req); else passed++;
    total++; if (bus_m.bus_addr !== 32'h0) $display("FAIL single_addr act=%0h exp=0", bus_m.bus_addr); else passed++;
    total++; if (stallreq_m !== 1'b0) $display("FAIL single_ack_stallreq act=%0h exp=0", stallreq_m); else passed++;
    step();
    bus_m.bus_ack = 1'b0; ce_i = 1'b0;
    #1;
    total++; if (bus_m.bus_req !== 1'b0) $display("FAIL single_req_drop act=%0h exp=0", bus_m.bus_req); else passed++;
    total++; if (inst_m !== 32'h34011100) $display("FAIL single_inst act=%0h exp=34011100", inst_m); else passed++;
    total++; if (pc_m !== 32'h0) $display("FAIL single_pc act=%0h exp=0", pc_m); else passed++;
    total++; if (valid_m !== 1'b1) $display("FAIL single_valid act=%0h exp=1", valid_m); else passed++;
  endtask

  task automatic test_back_to_back;
    logic [31:0] data [3];
    data[0] = 32'h11110000; data[1] = 32'h22220004; data[2] = 32'h33330008;
    do_reset();
    ce_i = 1'b1;
    for (int k = 0; k < 3; k++) begin
      pc_i = 32'(4 * k);
      #1;
      total++; if (stallreq_m !== 1'b1) $display("FAIL b2b_idle_stallreq k=%0d act=%0h exp=1", k, stallreq_m); else passed++;
      total++; if (bus_m.bus_req !== 1'b0) $display("FAIL b2b_idle_req k=%0d act=%0h exp=0", k, bus_m.bus_req); else passed++;
      step();
      for (int w = 0; w < 2; w++) begin
        #1;
        total++; if (bus_m.bus_req !== 1'b1 || bus_m.bus_addr !== 32'(4 * k))
          $display("FAIL b2b_wait k=%0d w=%0d act_req=%0h act_addr=%0h exp_addr=%0h", k, w, bus_m.bus_req, bus_m.bus_addr, 4 * k); else passed++;
        total++; if (stallreq_m !== 1'b1) $display("FAIL b2b_wait_stallreq k=%0d act=%0h exp=1", k, stallreq_m); else passed++;
        step();
      end
      bus_m.bus_ack = 1'b1; bus_m.bus_rdata = data[k];
      #1;
      total++; if (stallreq_m !== 1'b0) $display("FAIL b2b_ack_stallreq k=%0d act=%0h exp=0", k, stallreq_m); else passed++;
      step();
      bus_m.bus_ack = 1'b0;
      #1;
      total++; if (valid_m !== 1'b1 || inst_m !== data[k] || pc_m !== 32'(4 * k))
        $display("FAIL b2b_slot k=%0d act_valid=%0h act_inst=%0h act_pc=%0h exp_inst=%0h exp_pc=%0h", k, valid_m, inst_m, pc_m, data[k], 4 * k); else passed++;
    end
    ce_i = 1'b0;
  endtask

  task automatic test_stall;
    do_reset();
    ce_i = 1'b1; pc_i = 32'h100;
    step();
    bus_m.bus_ack = 1'b1; bus_m.bus_rdata = 32'hCAFE0100;
    step();
    bus_m.bus_ack = 1'b0; stall_i = 6'b000010; pc_i = 32'h104;
    for (int i = 0; i < 5; i++) begin
      #1;
      total++; if (bus_m.bus_req !== 1'b0) $display("FAIL stall_req i=%0d act=%0h exp=0", i, bus_m.bus_req); else passed++;
      total++; if (valid_m !== 1'b1 || inst_m !== 32'hCAFE0100 || pc_m !== 32'h100)
        $display("FAIL stall_hold i=%0d act_valid=%0h act_inst=%0h act_pc=%0h exp_inst=cafe0100 exp_pc=100", i, valid_m, inst_m, pc_m); else passed++;
      step();
    end
    stall_i = 6'h0;
    step();
    total++; if (bus_m.bus_req !== 1'b1 || bus_m.bus_addr !== 32'h104)
      $display("FAIL stall_release act_req=%0h act_addr=%0h exp_addr=104", bus_m.bus_req, bus_m.bus_addr); else passed++;
    total++; if (valid_m !== 1'b0) $display("FAIL stall_consumed act=%0h exp=0", valid_m); else passed++;
    ce_i = 1'b0; bus_m.bus_ack = 1'b1;
    step();
    bus_m.bus_ack = 1'b0;
  endtask

  task automatic test_flush;
    do_reset();
    ce_i = 1'b1; pc_i = 32'h200;
    step();
    step();
    step();
    flush_i = 1'b1; pc_i = 32'h300;
    step();
    flush_i = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #1;
      total++; if (bus_m.bus_req !== 1'b1 || bus_m.bus_addr !== 32'h200)
        $display("FAIL flush_discard_req i=%0d act_req=%0h act_addr=%0h exp_addr=200", i, bus_m.bus_req, bus_m.bus_addr); else passed++;
      total++; if (valid_m !== 1'b0 || stallreq_m !== 1'b1)
        $display("FAIL flush_discard i=%0d act_valid=%0h act_stallreq=%0h exp=0/1", i, valid_m, stallreq_m); else passed++;
      step();
    end
    bus_m.bus_ack = 1'b1; bus_m.bus_rdata = 32'hDEADBEEF;
    #1;
    total++; if (stallreq_m !== 1'b1) $display("FAIL flush_ack_stallreq act=%0h exp=1", stallreq_m); else passed++;
    step();
    bus_m.bus_ack = 1'b0;
    #1;
    total++; if (valid_m !== 1'b0 || bus_m.bus_req !== 1'b0)
      $display("FAIL flush_dropped act_valid=%0h act_req=%0h exp=0/0", valid_m, bus_m.bus_req); else passed++;
    step();
    total++; if (bus_m.bus_req !== 1'b1 || bus_m.bus_addr !== 32'h300)
      $display("FAIL flush_refetch act_req=%0h act_addr=%0h exp_addr=300", bus_m.bus_req, bus_m.bus_addr); else passed++;
    bus_m.bus_ack = 1'b1; bus_m.bus_rdata = 32'h00000300;
    step();
    bus_m.bus_ack = 1'b0; ce_i = 1'b0;
    #1;
    total++; if (valid_m !== 1'b1 || inst_m !== 32'h00000300 || pc_m !== 32'h300)
      $display("FAIL flush_newslot act_valid=%0h act_inst=%0h act_pc=%0h exp_inst=300 exp_pc=300", valid_m, inst_m, pc_m); else passed++;
  endtask

  task automatic test_timeout;
    do_reset();
    ce_i = 1'b1; pc_i = 32'h40;
    step();
    for (int c = 0; c < 3; c++) begin
      #1;
      total++; if (bus_t.bus_req !== 1'b1 || stallreq_t !== 1'b1)
        $display("FAIL to_wait c=%0d act_req=%0h act_stallreq=%0h exp=1/1", c, bus_t.bus_req, stallreq_t); else passed++;
      step();
    end
    #1;
    total++; if (bus_t.bus_req !== 1'b1 || stallreq_t !== 1'b0)
      $display("FAIL to_last act_req=%0h act_stallreq=%0h exp=1/0", bus_t.bus_req, stallreq_t); else passed++;
    step();
    ce_i = 1'b0;
    #1;
    total++; if (bus_t.bus_req !== 1'b0) $display("FAIL to_req_drop act=%0h exp=0", bus_t.bus_req); else passed++;
    total++; if (inst_t !== 32'h0 || err_t !== 1'b1 || valid_t !== 1'b1 || pc_t !== 32'h40)
      $display("FAIL to_slot act_inst=%0h act_err=%0h act_valid=%0h act_pc=%0h exp=0/1/1/40", inst_t, err_t, valid_t, pc_t); else passed++;
  endtask

  task automatic test_reset_mid;
    do_reset();
    ce_i = 1'b1; pc_i = 32'h80;
    step();
    total++; if (bus_m.bus_req !== 1'b1) $display("FAIL rmid_req act=%0h exp=1", bus_m.bus_req); else passed++;
    rst = 1'b1; bus_m.bus_ack = 1'b1; bus_m.bus_rdata = 32'h12345678;
    step();
    rst = 1'b0; ce_i = 1'b0;
    #1;
    total++; if (bus_m.bus_req !== 1'b0 || bus_m.bus_addr !== 32'h0 || valid_m !== 1'b0 || inst_m !== 32'h0 || pc_m !== 32'h0 || err_m !== 1'b0)
      $display("FAIL rmid_outputs act_req=%0h act_addr=%0h act_valid=%0h act_inst=%0h act_pc=%0h act_err=%0h exp=all0",
               bus_m.bus_req, bus_m.bus_addr, valid_m, inst_m, pc_m, err_m); else passed++;
    total++; if (stallreq_m !== 1'b0) $display("FAIL rmid_idle act=%0h exp=0", stallreq_m); else passed++;
    step();
    bus_m.bus_ack = 1'b0;
    #1;
    total++; if (valid_m !== 1'b0 || bus_m.bus_req !== 1'b0)
      $display("FAIL rmid_late_ack act_valid=%0h act_req=%0h exp=0/0", valid_m, bus_m.bus_req); else passed++;
  endtask

  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_stall();
    test_flush();
    test_timeout();
    test_reset_mid();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
